// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider (DIV/DIVU, truncating): accept in IDLE, 32 BUSY cycles, complete pulse in cycle 33.
// No backpressure; the requester holds div high until complete, and dropping div mid-operation aborts it.
module div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        div,
  input  logic        div_signed,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] s,
  output logic [31:0] r,
  output logic        complete,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] b_q, b_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] s_q, s_d;
  logic [31:0] r_q, r_d;

  logic [32:0] t;
  logic [32:0] diff;
  logic [31:0] quo_step;
  logic [31:0] rem_step;

  // quo starts as the dividend magnitude and is shifted out MSB-first while quotient bits shift in
  assign t        = {rem_q, quo_q[31]};
  assign diff     = t - {1'b0, b_q};
  assign quo_step = {quo_q[30:0], ~diff[32]};
  assign rem_step = diff[32] ? t[31:0] : diff[31:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    b_d     = b_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    s_d     = s_q;
    r_d     = r_q;
    case (state_q)
      ST_IDLE: begin
        if (div) begin
          state_d = ST_BUSY;
          cnt_d   = 6'd0;
          rem_d   = 32'd0;
          quo_d   = (div_signed & x[31]) ? -x : x;
          b_d     = (div_signed & y[31]) ? -y : y;
          q_neg_d = div_signed & (x[31] ^ y[31]);
          r_neg_d = div_signed & x[31];
        end
      end
      ST_BUSY: begin
        if (!div) begin
          state_d = ST_IDLE;
        end else begin
          quo_d = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = ST_DONE;
            s_d     = q_neg_q ? -quo_step : quo_step;
            r_d     = r_neg_q ? -rem_step : rem_step;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      b_q     <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      s_q     <= 32'd0;
      r_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      b_q     <= b_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      s_q     <= s_d;
      r_q     <= r_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign complete = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases from the divide semantics plus random operands
// compared against an arithmetic reference model.
module tb_div_iter;

  logic        clk;
  logic        reset;
  logic        div;
  logic        div_signed;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] s;
  logic [31:0] r;
  logic        complete;
  logic        busy;

  int checks = 0;
  int errors = 0;

  div_iter dut (
    .clk        (clk),
    .reset      (reset),
    .div        (div),
    .div_signed (div_signed),
    .x          (x),
    .y          (y),
    .s          (s),
    .r          (r),
    .complete   (complete),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, plus the defined divide-by-zero result
  function automatic logic [63:0] model(input logic sg, input logic [31:0] xv, input logic [31:0] yv);
    longint      xs, ys;
    logic [31:0] q, rm;
    if (!sg) begin
      if (yv == 32'd0) begin q = 32'hFFFFFFFF; rm = xv; end
      else begin q = xv / yv; rm = xv % yv; end
    end else begin
      xs = longint'($signed(xv));
      ys = longint'($signed(yv));
      if (ys == 0) begin q = xv[31] ? 32'd1 : 32'hFFFFFFFF; rm = xv; end
      else begin q = 32'(xs / ys); rm = 32'(xs % ys); end
    end
    return {q, rm};
  endfunction

  // Called #1 after a posedge; leaves div low for one cycle before returning.
  task automatic run_div(input string tag, input logic sg, input logic [31:0] xv, input logic [31:0] yv,
                         input logic [31:0] es, input logic [31:0] er);
    int          done_n = 0;
    int          ncomp  = 0;
    int          nbusy  = 0;
    logic [31:0] so = 32'd0;
    logic [31:0] ro = 32'd0;
    div = 1'b1; div_signed = sg; x = xv; y = yv;
    for (int n = 1; n <= 34; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        x = $urandom; y = $urandom; div_signed = 1'($urandom);
      end
      if (complete) begin ncomp++; done_n = n; so = s; ro = r; end
      if (busy) nbusy++;
      if (n == 34) div = 1'b0;
    end
    check({tag, "_lat"}, 32'(done_n), 32'd33);
    check({tag, "_ncomp"}, 32'(ncomp), 32'd1);
    check({tag, "_busy"}, 32'(nbusy), 32'd33);
    check({tag, "_s"}, so, es);
    check({tag, "_r"}, ro, er);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] m;
    logic [31:0] ps, pr, rx, ry;
    logic        rs;
    int          ncomp;
    reset = 1'b1; div = 1'b0; div_signed = 1'b0; x = 32'd0; y = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s", s, 32'd0);
    check("rst_r", r, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_comp", 32'(complete), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("sn7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("s7_n2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    run_div("sn7_n2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
    run_div("s_min_n1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    run_div("u_min_n1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run_div("u_dz", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);
    run_div("s_dz", 1'b1, 32'hFFFFFFFB, 32'd0, 32'd1, 32'hFFFFFFFB);

    // Abort by dropping div mid-operation: previous results must survive
    ps = s; pr = r;
    div = 1'b1; div_signed = 1'b0; x = 32'd1000; y = 32'd3;
    repeat (5) @(posedge clk);
    #1 div = 1'b0;
    ncomp = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (complete) ncomp++;
    end
    check("abort_ncomp", 32'(ncomp), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_s", s, ps);
    check("abort_r", r, pr);

    // Synchronous reset in BUSY cycle 10 discards the operation
    div = 1'b1; div_signed = 1'b0; x = 32'd1000; y = 32'd3;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; div = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_comp", 32'(complete), 32'd0);
    check("mrst_s", s, 32'd0);
    check("mrst_r", r, 32'd0);
    ncomp = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (complete) ncomp++;
    end
    check("mrst_ncomp", 32'(ncomp), 32'd0);
    run_div("after_rst", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2);

    // Back-to-back: div stays high through DONE, low one cycle, then a new request
    run_div("b2b_a", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("b2b_b", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1);

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom);
      rx = $urandom;
      case ($urandom_range(0, 3))
        0: ry = $urandom;
        1: ry = $urandom_range(1, 255);
        2: ry = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(1, 65535);
        default: ry = {16'hFFFF, 16'($urandom)};
      endcase
      if (i == 0) begin rs = 1'b1; rx = 32'h80000000; ry = 32'd1; end
      m = model(rs, rx, ry);
      run_div("rand", rs, rx, ry, m[63:32], m[31:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit radix-2 restoring divider for the execute stage. It is the responder side of the ALU's divide handshake. The ALU holds `div` high with stable operands until this block pulses `complete`, and reads quotient `s` and remainder `r` in that same cycle. It supports signed (DIV) and unsigned (DIVU) division with MIPS truncating semantics.

## Interface
- (no parameters) — operand width fixed at 32 bits.

- `clk` in 1 — single clock.
- `reset` in 1 — synchronous, active-high reset.
- `div` in 1 — request level. Held high by the ALU from issue until the cycle after `complete`.
- `div_signed` in 1 — 1 = signed divide (DIV), 0 = unsigned divide (DIVU). Sampled at acceptance.
- `x` in 32 — dividend. Sampled at acceptance.
- `y` in 32 — divisor. Sampled at acceptance.
- `s` out 32 — quotient. Registered.
- `r` out 32 — remainder. Registered.
- `complete` out 1 — one-cycle pulse; `s`/`r` are valid in this cycle.
- `busy` out 1 — high in BUSY and DONE.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `div`=1 → capture the inputs, go to BUSY, counter = 0.
  - `div`=0 → stay in IDLE.
- Capture:
  - Latch `sgn` = `div_signed`.
  - `q_neg` = sgn & (x[31]^y[31]).
  - `r_neg` = sgn & x[31].
  - `a` = |x| if sgn, else x.
  - `b` = |y| if sgn, else y.
  - Magnitudes are 32-bit unsigned; |0x80000000| = 0x80000000.
- BUSY: one iteration per cycle for 32 cycles.
  - t = {rem[31:0], quo[31]} (33 bits).
  - d = t − {1'b0, b}.
  - If d[32]=0: rem ← d, quo ← {quo[30:0], 1}.
  - Else: rem ← t, quo ← {quo[30:0], 0}.
  - Counter is 6 bits. After iteration 31, go to DONE.
- BUSY with `div`=0 (pipeline flush):
  - Abort to IDLE next cycle.
  - No `complete`; `s`/`r` are unchanged.
- DONE:
  - `complete`=1.
  - s = q_neg ? −quo : quo.
  - r = r_neg ? −rem[31:0] : rem[31:0].
  - `s`/`r` are registered so they are valid throughout DONE.
  - Next state is always IDLE, whatever the value of `div`.
  - `div`=1 during DONE is never a new request, because the ALU clears `div` on the `complete` edge.
- `s`/`r` hold their values until the next DONE.
- Divide by zero produces a defined result, with no trap:
  - Magnitude quotient = 0xFFFFFFFF, remainder = a.
  - Unsigned: s = 0xFFFFFFFF, r = x.
  - Signed: s = x[31] ? 0x00000001 : 0xFFFFFFFF, r = x.
- Signed 0x80000000 / 0xFFFFFFFF gives s = 0x80000000, r = 0 (wraps; no overflow flag).
- Sign rules: the quotient truncates toward zero, and the remainder takes the sign of the dividend.

## Timing
- Reset, in any state: next cycle state = IDLE; `complete`=0, `busy`=0, `s`=0, `r`=0, counter = 0.
  - Reset mid-BUSY discards the operation; no `complete` follows.
- Latency:
  - `div` is seen high in IDLE at cycle 0.
  - BUSY occupies cycles 1–32.
  - `complete`=1 in cycle 33 only.
  - Fixed 34-cycle occupancy including acceptance; no early termination.
- Back-to-back requests: the earliest re-acceptance is cycle 34, in IDLE, if `div`=1 again.
- `x`, `y` and `div_signed` may change after acceptance without affecting the result.
- `complete` is never high in two consecutive cycles.

## Test plan
- **Unsigned divide, latency check.** Unsigned x=100, y=7, `div` high from cycle 0 → `complete` only in cycle 33, with s=14, r=2. `busy` is high in cycles 1–33.
- **Signed sign combinations.**
  - x=0xFFFFFFF9 (−7), y=2 → s=0xFFFFFFFD, r=0xFFFFFFFF.
  - x=7, y=0xFFFFFFFE → s=0xFFFFFFFD, r=1.
  - x=−7, y=−2 → s=3, r=0xFFFFFFFF.
- **Edge operands.**
  - Signed 0x80000000 / 0xFFFFFFFF → s=0x80000000, r=0.
  - Unsigned, same operands → s=0, r=0x80000000.
- **Divide by zero.**
  - Unsigned x=5, y=0 → s=0xFFFFFFFF, r=5.
  - Signed x=0xFFFFFFFB, y=0 → s=1, r=0xFFFFFFFB.
- **Reset and abort mid-operation.**
  - Assert `reset` in cycle 10 of BUSY → no `complete`; s=r=0, `busy`=0. A following request 20/3 gives s=6, r=2 after 33 cycles.
  - Dropping `div` in BUSY → no `complete`, and the previous `s`/`r` are retained.
- **Back-to-back requests.**
  - `div` is held high through the DONE cycle, low for 1 cycle, then high with 9/4.
  - Expect exactly one `complete` for the first request, no spurious acceptance in DONE, then a second `complete` 33 cycles after re-acceptance with s=2, r=1.
